// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter.
//   - arb_state_e : port sequencer states (IDLE -> WAIT_MOC -> RELEASE)
//   - PORT_*      : requester identifiers carried in the grant register
//   - RW_*        : RAM RW line levels
//   - OPC_LW      : opcode forced onto the RAM for instruction fetches
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MOC = 2'd1,
        RELEASE  = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [5:0] OPC_LW = 6'b100011;

endpackage

// File: rtl/mem_arb_watchdog.sv
// MOC watchdog: loadable up-counter with clear/enable and an expiry flag.
//   clk, reset   : clock, synchronous active-high reset
//   clr_i        : force count to zero (highest priority after reset)
//   load_i       : load load_val_i
//   load_val_i   : value to load
//   en_i         : count up by one
//   expired_o    : count has reached TIMEOUT-1
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (load_i) cnt_d = load_val_i;
        else if (en_i)   cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences the single RAM port (MOV/RW/MOC four-phase handshake) and shares
// it between instruction fetch (IF) and load/store (DM).
//   clk, reset              : clock, synchronous active-high reset
//   if_req/if_addr          : fetch request (word read), held until if_done
//   if_done/if_rdata        : fetch completion pulse / fetched word (held)
//   dm_req/dm_rw/dm_addr/
//   dm_opc/dm_wdata         : load/store request, held until dm_done
//   dm_done/dm_rdata        : data completion pulse / load data (held)
//   bus_err                 : pulses with done when the access timed out
//   ram_mov/ram_rw/ram_addr/
//   ram_opc/ram_wdata       : registered drive to the RAM
//   ram_moc/ram_rdata       : RAM completion and read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned OPC_W        = 6,
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_rw,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [OPC_W-1:0]  dm_opc,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              bus_err,
    output logic              ram_mov,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [OPC_W-1:0]  ram_opc,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_moc,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              ram_mov_q, ram_mov_d;
    logic              ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [OPC_W-1:0]  ram_opc_q, ram_opc_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic any_req, pick_if, wd_expired;

    assign any_req = if_req | dm_req;
    // DM has priority unless IF has already been passed over MAX_DATA_RUN times.
    assign pick_if = if_req & (~dm_req | (run_cnt_q == RUN_MAX));

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .clr_i      ((state_q == IDLE) & any_req),
        .en_i       (state_q == WAIT_MOC),
        .load_i     (1'b0),
        .load_val_i ('0),
        .expired_o  (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= PORT_IF;
            run_cnt_q   <= '0;
            ram_mov_q   <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_opc_q   <= '0;
            ram_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            run_cnt_q   <= run_cnt_d;
            ram_mov_q   <= ram_mov_d;
            ram_rw_q    <= ram_rw_d;
            ram_addr_q  <= ram_addr_d;
            ram_opc_q   <= ram_opc_d;
            ram_wdata_q <= ram_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            bus_err_q   <= bus_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (any_req)                state_d = WAIT_MOC;
            WAIT_MOC: if (ram_moc || wd_expired)  state_d = RELEASE;
            RELEASE:  if (!ram_moc)               state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d       = gnt_q;
        run_cnt_d   = run_cnt_q;
        ram_mov_d   = ram_mov_q;
        ram_rw_d    = ram_rw_q;
        ram_addr_d  = ram_addr_q;
        ram_opc_d   = ram_opc_q;
        ram_wdata_d = ram_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        bus_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        unique case (state_q)
            IDLE: begin
                // A DM grant with IF waiting implies run_cnt < max, so no saturation test.
                if (!if_req || pick_if) run_cnt_d = '0;
                else                    run_cnt_d = run_cnt_q + 1'b1;
                if (any_req) begin
                    ram_mov_d = 1'b1;
                    if (pick_if) begin
                        gnt_d       = PORT_IF;
                        ram_rw_d    = RW_READ;
                        ram_addr_d  = if_addr;
                        ram_opc_d   = OPC_W'(OPC_LW);
                        ram_wdata_d = '0;
                    end else begin
                        gnt_d       = PORT_DM;
                        ram_rw_d    = dm_rw;
                        ram_addr_d  = dm_addr;
                        ram_opc_d   = dm_opc;
                        ram_wdata_d = dm_wdata;
                    end
                end
            end
            WAIT_MOC: begin
                if (ram_moc || wd_expired) begin
                    ram_mov_d = 1'b0;
                    bus_err_d = ~ram_moc;
                    if (gnt_q == PORT_IF) begin
                        if_done_d = 1'b1;
                        if (ram_moc && ram_rw_q == RW_READ) if_rdata_d = ram_rdata;
                    end else begin
                        dm_done_d = 1'b1;
                        if (ram_moc && ram_rw_q == RW_READ) dm_rdata_d = ram_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign ram_mov   = ram_mov_q;
    assign ram_rw    = ram_rw_q;
    assign ram_addr  = ram_addr_q;
    assign ram_opc   = ram_opc_q;
    assign ram_wdata = ram_wdata_q;

endmodule
